btn_scan: RTL

BTN_SCAN -- requirements
Module: btn_scan

---
 rtl/btn_scan.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/btn_scan.sv
// btn_scan: multi-channel button front end.
// Each raw input is synchronized, debounced, and then either queued as a
// press event with ack handshake (EDGE_MODE=1) or encoded as a registered
// highest-pressed-index level (EDGE_MODE=0).
module btn_scan #(
  parameter int N         = 25,
  parameter int W         = 6,
  parameter int DB_CYCLES = 4,
  parameter int EDGE_MODE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] btn_raw,
  input  logic         btn_ack,
  output logic [W-1:0] btn,
  output logic         btn_en,
  output logic [N-1:0] btn_held,
  output logic         btn_ovf
);

  // Counter only needs to reach DB_CYCLES-1; keep at least one bit.
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [N-1:0]  ONE_N    = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0]         sync1_q, sync2_q;
  logic [N-1:0]         deb_q, deb_d;
  logic [N-1:0][CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]         press;

  logic [W-1:0] btn_q, btn_d;
  logic         btn_en_q, btn_en_d;
  logic         ovf_q, ovf_d;

  // Highest set bit index, 0 when the vector is empty.
  function automatic logic [W-1:0] top_index(input logic [N-1:0] v);
    top_index = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) top_index = W'(i);
    end
  endfunction

  // Two-stage synchronizer for the asynchronous button levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: the level must disagree for DB_CYCLES consecutive edges
  // before it is accepted; press flags the accepted 0->1 transition.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    press = '0;
    for (int i = 0; i < N; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = '0;
        press[i] = sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_q <= '0;
      cnt_q <= '0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  generate
    if (EDGE_MODE != 0) begin : g_event
      logic [N-1:0] pend_q, pend_d;
      logic [N-1:0] sel_oh;
      logic [N-1:0] merge;

      // Event queue: pending[btn] stays set while presented and is
      // dropped by the ack; a press landing on an already-queued or
      // presented channel is merged and flagged as overflow.
      always_comb begin
        sel_oh   = btn_en_q ? (ONE_N << btn_q) : '0;
        merge    = press & (pend_q | sel_oh);
        ovf_d    = ovf_q | (|merge);
        pend_d   = pend_q | press;
        btn_d    = btn_q;
        btn_en_d = btn_en_q;
        if (btn_en_q) begin
          if (btn_ack) begin
            btn_en_d = 1'b0;
            pend_d   = pend_d & ~sel_oh;
          end
        end else if (|pend_q) begin
          btn_d    = top_index(pend_q);
          btn_en_d = 1'b1;
        end
      end

      // Pending press bitmap.
      always_ff @(posedge clk) begin
        if (rst) pend_q <= '0;
        else     pend_q <= pend_d;
      end
    end else begin : g_level
      // Level encoder: highest debounced channel wins.
      always_comb begin
        btn_d    = top_index(deb_q);
        btn_en_d = |deb_q;
        ovf_d    = 1'b0;
      end
    end
  endgenerate

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q    <= '0;
      btn_en_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      btn_q    <= btn_d;
      btn_en_q <= btn_en_d;
      ovf_q    <= ovf_d;
    end
  end

  assign btn      = btn_q;
  assign btn_en   = btn_en_q;
  assign btn_held = deb_q;
  assign btn_ovf  = ovf_q;

endmodule
